// File: rtl/display_mux_6dig.sv
// Six-digit multiplexed 7-segment scanner for an HH:MM:SS clock.
// Inputs are snapshotted once per frame; outputs are registered with inter-digit blanking.
module display_mux_6dig #(
    parameter int SCAN_DIV  = 16667,
    parameter int BLANK_CYC = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] left_seconds_in,
    input  logic [3:0] right_seconds_in,
    input  logic [3:0] left_minutes_in,
    input  logic [3:0] right_minutes_in,
    input  logic [3:0] left_hours_in,
    input  logic [3:0] right_hours_in,
    input  logic       blank_lead_zero,
    output logic [6:0] seg_out,
    output logic       dp_out,
    output logic [5:0] an_out,
    output logic       frame_start
);

    localparam int              CW         = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0]   PRESC_LAST = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0]   BLANK_END  = CW'(BLANK_CYC);
    localparam logic [2:0]      SLOT_LAST  = 3'd5;

    logic [CW-1:0]   presc;
    logic [2:0]      slot;
    logic [5:0][3:0] shadow;   // index = slot number
    logic            snap;

    logic [3:0] digit;
    logic       blank_now;
    logic [6:0] seg_next;
    logic [5:0] an_next;
    logic       dp_next;

    function automatic logic [6:0] decode(input logic [3:0] d);
        case (d)
            4'd0:    decode = 7'h40;
            4'd1:    decode = 7'h79;
            4'd2:    decode = 7'h24;
            4'd3:    decode = 7'h30;
            4'd4:    decode = 7'h19;
            4'd5:    decode = 7'h12;
            4'd6:    decode = 7'h02;
            4'd7:    decode = 7'h78;
            4'd8:    decode = 7'h00;
            4'd9:    decode = 7'h10;
            default: decode = 7'h3F;   // invalid BCD shows a dash
        endcase
    endfunction

    assign snap = (slot == 3'd0) && (presc == '0);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            presc       <= '0;
            slot        <= '0;
            // NOTE: the shadow bank is a handful of flops, not a RAM, so it is
            // cleared with everything else to give a known display after reset.
            shadow      <= '0;
            frame_start <= 1'b0;
        end else begin
            if (presc == PRESC_LAST) begin
                presc <= '0;
                slot  <= (slot == SLOT_LAST) ? 3'd0 : slot + 3'd1;
            end else begin
                presc <= presc + 1'b1;
            end
            if (snap) begin
                shadow <= {left_hours_in, right_hours_in, left_minutes_in,
                           right_minutes_in, left_seconds_in, right_seconds_in};
            end
            frame_start <= snap;
        end
    end

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        digit     = 4'd0;
        seg_next  = 7'h7F;
        an_next   = 6'h3F;
        dp_next   = 1'b1;
        case (slot)
            3'd0:    digit = shadow[0];
            3'd1:    digit = shadow[1];
            3'd2:    digit = shadow[2];
            3'd3:    digit = shadow[3];
            3'd4:    digit = shadow[4];
            3'd5:    digit = shadow[5];
            default: digit = 4'd0;
        endcase
        // Leading-zero suppression follows the live control, not the snapshot.
        blank_now = (presc < BLANK_END) ||
                    ((slot == SLOT_LAST) && blank_lead_zero && (shadow[5] == 4'd0));
        if (!blank_now) begin
            an_next  = ~(6'b000001 << slot);
            seg_next = decode(digit);
            dp_next  = !(((slot == 3'd2) || (slot == 3'd4)) && !shadow[0][0]);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            seg_out <= 7'h7F;
            an_out  <= 6'h3F;
            dp_out  <= 1'b1;
        end else begin
            seg_out <= seg_next;
            an_out  <= an_next;
            dp_out  <= dp_next;
        end
    end

endmodule
